// File: rtl/alu_sched.sv
// alu_sched: round-robin scheduler sharing one combinational ALU between two valid/ready requesters.
module alu_sched #(
    parameter int WIDTH = 8,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_id,
    output logic             busy,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [OPW-1:0]   opcode,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             zero
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] in1_q, in1_d, in2_q, in2_d, data_q, data_d;
    logic [OPW-1:0]   op_q, op_d;
    logic             zero_q, zero_d, id_q, id_d, last_q, last_d;
    logic             any_req, gnt;
    assign any_req = req0_valid | req1_valid;
    // On a tie the requester that was not served last wins.
    assign gnt = (req0_valid & req1_valid) ? ~last_q : req1_valid;
    always_comb begin
        state_d = state_q;
        in1_d   = in1_q;
        in2_d   = in2_q;
        op_d    = op_q;
        data_d  = data_q;
        zero_d  = zero_q;
        id_d    = id_q;
        last_d  = last_q;
        case (state_q)
            IDLE: if (any_req) begin
                state_d = EXEC;
                in1_d   = gnt ? req1_a : req0_a;
                in2_d   = gnt ? req1_b : req0_b;
                op_d    = gnt ? req1_op : req0_op;
                id_d    = gnt;
                last_d  = gnt;
            end
            EXEC: begin
                state_d = RESP;
                data_d  = alu_out;
                zero_d  = zero;
            end
            RESP: state_d = rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            in1_q   <= '0;
            in2_q   <= '0;
            op_q    <= '0;
            data_q  <= '0;
            zero_q  <= 1'b0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            op_q    <= op_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end
    // Handshake strobes are masked during reset so no pulse escapes the reset cycle.
    assign req0_ready = !rst && state_q == IDLE && any_req && !gnt;
    assign req1_ready = !rst && state_q == IDLE && any_req && gnt;
    assign rsp_valid  = !rst && state_q == RESP;
    assign busy       = state_q != IDLE;
    assign rsp_data   = data_q;
    assign rsp_zero   = zero_q;
    assign rsp_id     = id_q;
    assign alu_in1    = in1_q;
    assign alu_in2    = in2_q;
    assign opcode     = op_q;
endmodule
